// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit_pkg : shared opcode field and fetch-FSM encodings
// Rev 1.0
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int OPCODE_W = 5;
    localparam int FS_BITS  = 2;

    typedef enum logic [FS_BITS-1:0] {
        FS_IDLE = 2'd0,
        FS_READ = 2'd1,
        FS_LOAD = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit_if : controller/loader bus of the instruction fetch unit
// Rev 1.0
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
);
    logic               fetch_req;
    logic               fetch_done;
    logic [INSTR_W-1:0] instr;
    logic [4:0]         opcode;
    logic [ADDR_W-1:0]  pc;
    logic               branch_en;
    logic [ADDR_W-1:0]  branch_target;
    logic               load_start;
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               load_ready;
    logic               busy;

    modport master (
        output fetch_req, branch_en, branch_target,
        output load_start, load_valid, load_data, load_last,
        input  fetch_done, instr, opcode, pc, load_ready, busy
    );

    modport slave (
        input  fetch_req, branch_en, branch_target,
        input  load_start, load_valid, load_data, load_last,
        output fetch_done, instr, opcode, pc, load_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_mem.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit_mem : single-port instruction RAM (instr_mem), sync read
// Rev 1.0
// ============================================================================
module instr_fetch_unit_mem #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  wire logic               clk,
    input  wire logic               we_i,
    input  wire logic               re_i,
    input  wire logic [ADDR_W-1:0]  addr_i,
    input  wire logic [INSTR_W-1:0] wdata_i,
    output      logic [INSTR_W-1:0] rdata_o
);
    localparam int DEPTH = 2**ADDR_W;

    logic [INSTR_W-1:0] mem_q [0:DEPTH-1];
    logic [INSTR_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : PC, instruction memory/register and program loader
// Rev 1.0
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_fetch_unit_if.slave  bus
);
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               fetch_done_q, fetch_done_d;
    logic               pend_fetch_q, pend_fetch_d;
    logic               pend_load_q, pend_load_d;

    logic               mem_we, mem_re;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               eff_load, eff_fetch;

    // Latched requests behave as live inputs on the first IDLE cycle.
    assign eff_load  = bus.load_start | pend_load_q;
    assign eff_fetch = bus.fetch_req  | pend_fetch_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_addr_d    = rd_addr_q;
        instr_d      = instr_q;
        fetch_done_d = 1'b0;
        pend_fetch_d = pend_fetch_q;
        pend_load_d  = pend_load_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = rd_addr_q;

        case (state_q)
            FS_IDLE: begin
                if (eff_load) begin
                    state_d      = FS_LOAD;
                    wr_ptr_d     = '0;
                    pend_load_d  = 1'b0;
                    pend_fetch_d = eff_fetch;
                end else if (eff_fetch) begin
                    state_d      = FS_READ;
                    pend_fetch_d = 1'b0;
                    // A replayed fetch always reads from pc, never a branch target.
                    rd_addr_d    = (bus.branch_en && !pend_fetch_q) ? bus.branch_target : pc_q;
                    mem_re       = 1'b1;
                    mem_addr     = rd_addr_d;
                end else if (bus.branch_en) begin
                    pc_d = bus.branch_target;
                end
            end
            FS_READ: begin
                instr_d      = mem_rdata;
                pc_d         = rd_addr_q + 1'b1;
                fetch_done_d = 1'b1;
                pend_load_d  = pend_load_q | bus.load_start;
                state_d      = FS_IDLE;
            end
            FS_LOAD: begin
                pend_fetch_d = pend_fetch_q | bus.fetch_req;
                mem_addr     = wr_ptr_q;
                if (bus.load_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (bus.load_last) begin
                        state_d = FS_IDLE;
                        pc_d    = '0;
                    end
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FS_IDLE;
            pc_q         <= '0;
            wr_ptr_q     <= '0;
            rd_addr_q    <= '0;
            instr_q      <= '0;
            fetch_done_q <= 1'b0;
            pend_fetch_q <= 1'b0;
            pend_load_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_addr_q    <= rd_addr_d;
            instr_q      <= instr_d;
            fetch_done_q <= fetch_done_d;
            pend_fetch_q <= pend_fetch_d;
            pend_load_q  <= pend_load_d;
        end
    end

    instr_fetch_unit_mem #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (bus.load_data),
        .rdata_o (mem_rdata)
    );

    assign bus.fetch_done = fetch_done_q;
    assign bus.instr      = instr_q;
    assign bus.opcode     = instr_q[INSTR_W-1 -: OPCODE_W];
    assign bus.pc         = pc_q;
    assign bus.load_ready = (state_q == FS_LOAD);
    assign bus.busy       = (state_q != FS_IDLE) | pend_fetch_q | pend_load_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : vector table + scoreboard bench for instr_fetch_unit
// Rev 1.0
// ============================================================================
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.INSTR_W(16), .ADDR_W(8)) bus ();

    instr_fetch_unit #(.INSTR_W(16), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        br;
        logic [7:0]  tgt;
        logic [15:0] exp_instr;
        logic [7:0]  exp_pc;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    vec_t        vecs [6];
    exp_t        sb [$];
    logic [15:0] model_mem [0:255];
    logic [15:0] ld_buf [0:511];
    logic [7:0]  model_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every fetch_done pops one expected result.
    always @(negedge clk) begin
        if (bus.fetch_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_fetch_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instr", 32'(bus.instr), 32'(e.instr));
                check("sb_opcode", 32'(bus.opcode), 32'(e.instr[15:11]));
                check("sb_pc", 32'(bus.pc), 32'(e.pc));
            end
        end
    end

    task automatic fetch(input logic br, input logic [7:0] tgt,
                         input logic [15:0] exp_instr, input logic [7:0] exp_pc);
        exp_t e;
        e.instr = exp_instr;
        e.pc    = exp_pc;
        sb.push_back(e);
        bus.fetch_req     = 1'b1;
        bus.branch_en     = br;
        bus.branch_target = tgt;
        tick();
        bus.fetch_req = 1'b0;
        bus.branch_en = 1'b0;
        check("fetch_busy", 32'(bus.busy), 32'd1);
        check("fetch_done_early", 32'(bus.fetch_done), 32'd0);
        tick();
        check("fetch_latency", 32'(bus.fetch_done), 32'd1);
        model_pc = exp_pc;
    endtask

    task automatic fetch_model(input logic br, input logic [7:0] tgt);
        logic [7:0] a;
        a = br ? tgt : model_pc;
        fetch(br, tgt, model_mem[a], a + 8'd1);
    endtask

    task automatic load_prog(input int n, input logic with_fetch);
        int         ready_cnt;
        logic [7:0] wp;
        ready_cnt      = 0;
        wp             = 8'd0;
        bus.load_start = 1'b1;
        bus.fetch_req  = with_fetch;
        tick();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        check("load_ready_rise", 32'(bus.load_ready), 32'd1);
        check("load_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = ld_buf[i];
            bus.load_last  = (i == n - 1);
            if (bus.load_ready === 1'b1) ready_cnt++;
            tick();
            model_mem[wp] = ld_buf[i];
            wp = wp + 8'd1;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        if (bus.load_ready === 1'b1) ready_cnt++;
        check("load_ready_beats", 32'(ready_cnt), 32'(n));
        check("load_pc_zero", 32'(bus.pc), 32'd0);
        check("load_busy_after", 32'(bus.busy), 32'(with_fetch));
        model_pc = 8'd0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h00, 16'h0801, 8'h01};
        vecs[1] = '{1'b0, 8'h00, 16'h1002, 8'h02};
        vecs[2] = '{1'b1, 8'h03, 16'hF800, 8'h04};
        vecs[3] = '{1'b1, 8'h00, 16'h0801, 8'h01};
        vecs[4] = '{1'b1, 8'h02, 16'h1803, 8'h03};
        vecs[5] = '{1'b0, 8'h00, 16'hF800, 8'h04};

        reset             = 1'b1;
        bus.fetch_req     = 1'b0;
        bus.branch_en     = 1'b0;
        bus.branch_target = 8'h00;
        bus.load_start    = 1'b0;
        bus.load_valid    = 1'b0;
        bus.load_data     = 16'h0000;
        bus.load_last     = 1'b0;
        model_pc          = 8'd0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_fetch_done", 32'(bus.fetch_done), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        ld_buf[0] = 16'h0801; ld_buf[1] = 16'h1002;
        ld_buf[2] = 16'h1803; ld_buf[3] = 16'hF800;
        load_prog(4, 1'b0);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].br, vecs[i].tgt, vecs[i].exp_instr, vecs[i].exp_pc);
        end

        // Branch without fetch only moves pc.
        bus.branch_en     = 1'b1;
        bus.branch_target = 8'h10;
        tick();
        bus.branch_en = 1'b0;
        check("branch_only_pc", 32'(bus.pc), 32'h10);
        tick();
        check("branch_only_no_done", 32'(bus.fetch_done), 32'd0);
        check("branch_only_busy", 32'(bus.busy), 32'd0);
        model_pc = 8'h10;

        // load_start and fetch_req together: load first, then fetch from 0.
        ld_buf[0] = 16'h2222; ld_buf[1] = 16'h3333;
        load_prog(2, 1'b1);
        begin
            exp_t e;
            e.instr = 16'h2222;
            e.pc    = 8'h01;
            sb.push_back(e);
        end
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("collision_fetch_timeout", 32'(sb.size()), 32'd0);
        model_pc = 8'h01;
        tick();

        // load_start during READ is deferred until after fetch_done.
        begin
            exp_t e;
            e.instr = model_mem[model_pc];
            e.pc    = model_pc + 8'd1;
            sb.push_back(e);
        end
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("rdload_done", 32'(bus.fetch_done), 32'd1);
        check("rdload_ready_low", 32'(bus.load_ready), 32'd0);
        check("rdload_busy", 32'(bus.busy), 32'd1);
        tick();
        check("rdload_ready_high", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h4444;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("rdload_exit_ready", 32'(bus.load_ready), 32'd0);
        check("rdload_exit_pc", 32'(bus.pc), 32'd0);
        model_mem[0] = 16'h4444;
        model_pc     = 8'd0;
        fetch_model(1'b0, 8'h00);

        // Loader wrap: the 257th word lands on address 0.
        for (int i = 0; i < 256; i++) ld_buf[i] = 16'hA000 + 16'(i);
        ld_buf[256] = 16'h5A5A;
        load_prog(257, 1'b0);
        fetch(1'b1, 8'hFF, 16'hA0FF, 8'h00);
        fetch(1'b0, 8'h00, 16'h5A5A, 8'h01);

        // Reset after 2 of 4 load beats.
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h7001;
        tick();
        bus.load_data  = 16'h7002;
        tick();
        bus.load_valid = 1'b0;
        reset          = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_pc", 32'(bus.pc), 32'd0);
        check("abort_load_ready", 32'(bus.load_ready), 32'd0);
        check("abort_instr", 32'(bus.instr), 32'd0);
        model_mem[0] = 16'h7001;
        model_mem[1] = 16'h7002;
        model_pc     = 8'd0;
        fetch(1'b0, 8'h00, 16'h7001, 8'h01);
        fetch(1'b0, 8'h00, 16'h7002, 8'h02);
        fetch(1'b0, 8'h00, 16'hA002, 8'h03);
        fetch(1'b0, 8'h00, 16'hA003, 8'h04);

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
